// File: rtl/axi_r_xbar.sv
// axi_r_xbar: AXI R-channel crossbar, NS slave streams to NM masters.
// Define AXI_R_XBAR_RR_EN for round-robin; default is fixed priority.
module axi_r_xbar #(
    parameter int NS     = 3,
    parameter int NM     = 2,
    parameter int ID_W   = 4,
    parameter int DATA_W = 32,
    localparam int IDS_W = ID_W + NM
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NS*IDS_W-1:0]  s_rid,
    input  logic [NS*DATA_W-1:0] s_rdata,
    input  logic [NS*2-1:0]      s_rresp,
    input  logic [NS-1:0]        s_rlast,
    input  logic [NS-1:0]        s_rvalid,
    output logic [NS-1:0]        s_rready,
    output logic [NM*ID_W-1:0]   m_rid,
    output logic [NM*DATA_W-1:0] m_rdata,
    output logic [NM*2-1:0]      m_rresp,
    output logic [NM-1:0]        m_rlast,
    output logic [NM-1:0]        m_rvalid,
    input  logic [NM-1:0]        m_rready,
    output logic                 err_route
);
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;

    logic [NM-1:0]         lock;
    logic [NM-1:0][SW-1:0] lsel;
`ifdef AXI_R_XBAR_RR_EN
    logic [NM-1:0][SW-1:0] ptr;
`endif
    logic [NS-1:0][NM-1:0] tag;
    logic [NS-1:0][NM-1:0] lkd_by;
    logic [NS-1:0]         tag_ok;
    logic [NS-1:0]         lkd_any;
    logic [NS-1:0]         bad;
    logic [NM-1:0][NS-1:0] req;
    logic [NM-1:0][SW-1:0] gnt;
    logic [NM-1:0]         act;
    logic [NM-1:0]         hs;

    // Decode slave tags and which master currently holds each slave
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            tag[s]    = s_rid[s*IDS_W+ID_W +: NM];
            tag_ok[s] = (tag[s] != '0) && ((tag[s] & (tag[s] - NM'(1))) == '0);
            for (int m = 0; m < NM; m++)
                lkd_by[s][m] = lock[m] && (int'(lsel[m]) == s);
            lkd_any[s] = |lkd_by[s];
            bad[s]     = rstn && s_rvalid[s] && !tag_ok[s] && !lkd_any[s];
        end
    end

    // Per-master requests and grant: locked slave, else arbitration winner
    always_comb begin
        for (int m = 0; m < NM; m++) begin
            req[m] = '0;
            gnt[m] = '0;
            act[m] = 1'b0;
            for (int s = 0; s < NS; s++)
                req[m][s] = rstn && s_rvalid[s] && (tag[s] == NM'(1 << m))
                            && !(lkd_any[s] && !lkd_by[s][m]);
            if (lock[m]) begin
                gnt[m] = lsel[m];
                act[m] = rstn && s_rvalid[lsel[m]];
            end else begin
`ifdef AXI_R_XBAR_RR_EN
                // scan downward so the slave nearest ptr is written last
                for (int k = NS - 1; k >= 0; k--)
                    if (req[m][(int'(ptr[m]) + k) % NS])
                        gnt[m] = SW'((int'(ptr[m]) + k) % NS);
`else
                // ascending scan: highest requesting index wins
                for (int s = 0; s < NS; s++)
                    if (req[m][s])
                        gnt[m] = SW'(s);
`endif
                act[m] = |req[m];
            end
            hs[m] = act[m] && m_rready[m];
        end
    end

    // Route granted slave fields to masters; ready back to slaves
    always_comb begin
        m_rid    = '0;
        m_rdata  = '0;
        m_rresp  = {NM{2'b11}};
        m_rlast  = '0;
        m_rvalid = '0;
        s_rready = bad;
        for (int m = 0; m < NM; m++) begin
            if (act[m]) begin
                m_rid[m*ID_W +: ID_W]     = s_rid[int'(gnt[m])*IDS_W +: ID_W];
                m_rdata[m*DATA_W +: DATA_W] =
                    s_rdata[int'(gnt[m])*DATA_W +: DATA_W];
                m_rresp[m*2 +: 2]         = s_rresp[int'(gnt[m])*2 +: 2];
                m_rlast[m]                = s_rlast[gnt[m]];
                m_rvalid[m]               = 1'b1;
                if (m_rready[m])
                    s_rready[gnt[m]] = 1'b1;
            end
        end
    end

    // Burst lock, round-robin pointer and sticky routing error
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lock      <= '0;
            lsel      <= '0;
`ifdef AXI_R_XBAR_RR_EN
            ptr       <= '0;
`endif
            err_route <= 1'b0;
        end else begin
            for (int m = 0; m < NM; m++) begin
                if (hs[m]) begin
                    if (s_rlast[gnt[m]]) begin
                        lock[m] <= 1'b0;
`ifdef AXI_R_XBAR_RR_EN
                        ptr[m]  <= SW'((int'(gnt[m]) + 1) % NS);
`endif
                    end else begin
                        lock[m] <= 1'b1;
                        lsel[m] <= gnt[m];
                    end
                end
            end
            if (|bad)
                err_route <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_r_xbar.sv
// tb_axi_r_xbar: directed scenarios plus random traffic for axi_r_xbar,
// checked against a per-master lock/arbitration reference model.
module tb_axi_r_xbar;
    localparam int NS     = 3;
    localparam int NM     = 2;
    localparam int ID_W   = 4;
    localparam int DATA_W = 32;
    localparam int IDS_W  = ID_W + NM;
    localparam int OW     = 4*NM + NM*ID_W + NM*DATA_W + NS + 1;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic [NS*IDS_W-1:0]  s_rid = '0;
    logic [NS*DATA_W-1:0] s_rdata = '0;
    logic [NS*2-1:0]      s_rresp = '0;
    logic [NS-1:0]        s_rlast = '0;
    logic [NS-1:0]        s_rvalid = '0;
    logic [NS-1:0]        s_rready;
    logic [NM*ID_W-1:0]   m_rid;
    logic [NM*DATA_W-1:0] m_rdata;
    logic [NM*2-1:0]      m_rresp;
    logic [NM-1:0]        m_rlast;
    logic [NM-1:0]        m_rvalid;
    logic [NM-1:0]        m_rready = '0;
    logic                 err_route;

    axi_r_xbar #(.NS(NS), .NM(NM), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rstn(rstn),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .err_route(err_route)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    int mlock[NM];
    int msel[NM];
    int mptr[NM];
    bit merr;
    int g_sel[NM];
    bit g_act[NM];
    bit e_bad;
    logic [NM-1:0]        e_rvalid;
    logic [NM-1:0]        e_rlast;
    logic [NM*ID_W-1:0]   e_rid;
    logic [NM*DATA_W-1:0] e_rdata;
    logic [NM*2-1:0]      e_rresp;
    logic [NS-1:0]        e_srready;

    function automatic logic [OW-1:0] obs();
        return {m_rvalid, m_rlast, m_rid, m_rdata, m_rresp, s_rready, err_route};
    endfunction

    function automatic logic [OW-1:0] expv();
        return {e_rvalid, e_rlast, e_rid, e_rdata, e_rresp, e_srready, merr};
    endfunction

    task automatic model_reset();
        for (int m = 0; m < NM; m++) begin
            mlock[m] = 0;
            msel[m]  = 0;
            mptr[m]  = 0;
        end
        merr = 1'b0;
    endtask

    task automatic model_eval();
        int owner[NS];
        logic [NM-1:0] t;
        int best, key, bkey, g;
        e_rvalid  = '0;
        e_rlast   = '0;
        e_rid     = '0;
        e_rdata   = '0;
        e_rresp   = {NM{2'b11}};
        e_srready = '0;
        e_bad     = 1'b0;
        for (int m = 0; m < NM; m++) begin
            g_act[m] = 1'b0;
            g_sel[m] = 0;
        end
        if (!rstn) return;
        for (int s = 0; s < NS; s++) begin
            owner[s] = -1;
            for (int m = 0; m < NM; m++)
                if (mlock[m] != 0 && msel[m] == s) owner[s] = m;
        end
        for (int s = 0; s < NS; s++) begin
            t = s_rid[s*IDS_W+ID_W +: NM];
            if (s_rvalid[s] && $countones(t) != 1 && owner[s] < 0) begin
                e_srready[s] = 1'b1;
                e_bad = 1'b1;
            end
        end
        for (int m = 0; m < NM; m++) begin
            g = 0;
            if (mlock[m] != 0) begin
                g = msel[m];
                g_act[m] = s_rvalid[g];
            end else begin
                best = -1;
                bkey = NS;
                for (int s = 0; s < NS; s++) begin
                    t = s_rid[s*IDS_W+ID_W +: NM];
                    if (s_rvalid[s] && owner[s] < 0 && int'(t) == (1 << m)) begin
`ifdef AXI_R_XBAR_RR_EN
                        key = (s - mptr[m] + NS) % NS;
`else
                        key = NS - 1 - s;
`endif
                        if (key < bkey) begin
                            bkey = key;
                            best = s;
                        end
                    end
                end
                g_act[m] = (best >= 0);
                if (best >= 0) g = best;
            end
            g_sel[m] = g;
            if (g_act[m]) begin
                e_rvalid[m] = 1'b1;
                e_rid[m*ID_W +: ID_W] = s_rid[g*IDS_W +: ID_W];
                e_rdata[m*DATA_W +: DATA_W] = s_rdata[g*DATA_W +: DATA_W];
                e_rresp[m*2 +: 2] = s_rresp[g*2 +: 2];
                e_rlast[m] = s_rlast[g];
                if (m_rready[m]) e_srready[g] = 1'b1;
            end
        end
    endtask

    task automatic model_commit();
        int g;
        if (!rstn) return;
        if (e_bad) merr = 1'b1;
        for (int m = 0; m < NM; m++) begin
            if (g_act[m] && m_rready[m]) begin
                g = g_sel[m];
                if (s_rlast[g]) begin
                    mlock[m] = 0;
                    mptr[m]  = (g + 1) % NS;
                end else begin
                    mlock[m] = 1;
                    msel[m]  = g;
                end
            end
        end
    endtask

    task automatic set_s(input int s, input bit v, input logic [NM-1:0] t,
                         input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d,
                         input bit l, input logic [1:0] r);
        s_rvalid[s] = v;
        s_rid[s*IDS_W +: IDS_W] = {t, id};
        s_rdata[s*DATA_W +: DATA_W] = d;
        s_rlast[s] = l;
        s_rresp[s*2 +: 2] = r;
    endtask

    task automatic clear_all();
        s_rvalid = '0;
        s_rlast  = '0;
        s_rid    = '0;
        s_rdata  = '0;
        s_rresp  = '0;
        m_rready = '0;
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        clear_all();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        model_reset();
        for (int s = 0; s < NS; s++)
            set_s(s, 1'b1, 2'b01, ID_W'(s + 1), DATA_W'(32'hA5 + s), 1'b0, 2'b00);
        m_rready = '1;
        sample();
        checks++;
        if (m_rvalid !== 2'b00 || s_rready !== 3'b000) begin
            errors++;
            $display("FAIL reset_vld got m_rvalid=%b s_rready=%b want 00/000", m_rvalid, s_rready);
        end
        checks++;
        if (m_rresp !== 4'b1111 || m_rdata !== '0 || err_route !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got rresp=%b rdata=%h err=%b", m_rresp, m_rdata, err_route);
        end
        checks++;
        if (obs() !== expv()) begin
            errors++;
            $display("FAIL reset_all got=%h want=%h", obs(), expv());
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        clear_all();
    endtask

    task automatic test_burst_lock();
        do_reset();
        m_rready = 2'b01;
        for (int b = 0; b < 4; b++) begin
            set_s(1, 1'b1, 2'b01, 4'h5, 32'h1000 + b, b == 3, 2'b00);
            if (b >= 1) set_s(2, 1'b1, 2'b01, 4'h9, 32'h2222, 1'b1, 2'b01);
            sample();
            checks++;
            if (m_rdata[31:0] !== 32'h1000 + b || m_rid[3:0] !== 4'h5 ||
                m_rvalid[0] !== 1'b1 || s_rready !== 3'b010) begin
                errors++;
                $display("FAIL burst_beat%0d got rdata=%h rid=%h srdy=%b", b, m_rdata[31:0], m_rid[3:0], s_rready);
            end
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL burst_model%0d got=%h want=%h", b, obs(), expv());
            end
            tick();
        end
        set_s(1, 1'b0, 2'b01, 4'h5, 32'h0, 1'b0, 2'b00);
        sample();
        checks++;
        if (m_rdata[31:0] !== 32'h2222 || m_rresp[1:0] !== 2'b01 || s_rready !== 3'b100) begin
            errors++;
            $display("FAIL burst_next got rdata=%h resp=%b srdy=%b want 2222/01/100", m_rdata[31:0], m_rresp[1:0], s_rready);
        end
        tick();
        clear_all();
    endtask

    task automatic test_parallel();
        do_reset();
        set_s(0, 1'b1, 2'b01, 4'h3, 32'hA0A0, 1'b1, 2'b00);
        set_s(2, 1'b1, 2'b10, 4'hA, 32'hB0B0, 1'b1, 2'b10);
        m_rready = 2'b11;
        sample();
        checks++;
        if (m_rvalid !== 2'b11 || s_rready !== 3'b101) begin
            errors++;
            $display("FAIL par_hs got m_rvalid=%b s_rready=%b want 11/101", m_rvalid, s_rready);
        end
        checks++;
        if (m_rid !== 8'hA3 || m_rdata !== {32'hB0B0, 32'hA0A0} || m_rresp !== 4'b1000) begin
            errors++;
            $display("FAIL par_data got rid=%h rdata=%h resp=%b", m_rid, m_rdata, m_rresp);
        end
        checks++;
        if (obs() !== expv()) begin
            errors++;
            $display("FAIL par_model got=%h want=%h", obs(), expv());
        end
        tick();
        clear_all();
    endtask

    task automatic test_arbitration();
        int want;
        do_reset();
        for (int s = 0; s < NS; s++)
            set_s(s, 1'b1, 2'b10, ID_W'(s), DATA_W'(s), 1'b1, 2'b00);
        m_rready = 2'b10;
        for (int c = 0; c < 4; c++) begin
`ifdef AXI_R_XBAR_RR_EN
            want = c % 3;
`else
            want = 2;
`endif
            sample();
            checks++;
            if (m_rid[7:4] !== ID_W'(want) || m_rvalid[1] !== 1'b1) begin
                errors++;
                $display("FAIL arb_order%0d got slave=%0d want=%0d", c, m_rid[7:4], want);
            end
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL arb_model%0d got=%h want=%h", c, obs(), expv());
            end
            tick();
        end
        clear_all();
    endtask

    task automatic test_bad_tag();
        do_reset();
        set_s(0, 1'b1, 2'b11, 4'h3, 32'hDEAD, 1'b1, 2'b00);
        sample();
        checks++;
        if (s_rready !== 3'b001 || m_rvalid !== 2'b00 || err_route !== 1'b0) begin
            errors++;
            $display("FAIL badtag_now got srdy=%b mvld=%b err=%b want 001/00/0", s_rready, m_rvalid, err_route);
        end
        tick();
        set_s(0, 1'b0, 2'b00, 4'h0, 32'h0, 1'b0, 2'b00);
        sample();
        checks++;
        if (err_route !== 1'b1) begin
            errors++;
            $display("FAIL badtag_set got err=%b want 1", err_route);
        end
        tick();
        sample();
        checks++;
        if (err_route !== 1'b1 || obs() !== expv()) begin
            errors++;
            $display("FAIL badtag_hold got=%h want=%h", obs(), expv());
        end
        tick();
    endtask

    task automatic test_stall_reset();
        do_reset();
        m_rready = 2'b01;
        set_s(1, 1'b1, 2'b01, 4'h1, 32'h11, 1'b0, 2'b00);
        sample();
        checks++;
        if (s_rready !== 3'b010) begin
            errors++;
            $display("FAIL stall_first got srdy=%b want 010", s_rready);
        end
        tick();
        set_s(1, 1'b1, 2'b01, 4'h1, 32'h12, 1'b1, 2'b00);
        set_s(2, 1'b1, 2'b01, 4'h2, 32'h22, 1'b1, 2'b00);
        m_rready = 2'b00;
        for (int c = 0; c < 2; c++) begin
            sample();
            checks++;
            if (m_rid[3:0] !== 4'h1 || m_rlast[0] !== 1'b1 || s_rready !== 3'b000) begin
                errors++;
                $display("FAIL stall_hold%0d got rid=%h last=%b srdy=%b", c, m_rid[3:0], m_rlast[0], s_rready);
            end
            tick();
        end
        rstn = 1'b0;
        model_reset();
        set_s(1, 1'b0, 2'b01, 4'h1, 32'h0, 1'b0, 2'b00);
        #2;
        rstn = 1'b1;
        m_rready = 2'b01;
        sample();
        checks++;
        if (m_rid[3:0] !== 4'h2 || m_rvalid[0] !== 1'b1 || s_rready !== 3'b100) begin
            errors++;
            $display("FAIL stall_rst got rid=%h vld=%b srdy=%b want 2/1/100", m_rid[3:0], m_rvalid[0], s_rready);
        end
        checks++;
        if (obs() !== expv()) begin
            errors++;
            $display("FAIL stall_model got=%h want=%h", obs(), expv());
        end
        tick();
        clear_all();
    endtask

    task automatic test_random();
        logic [NM-1:0] t;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom % 150 == 0) begin
                rstn = 1'b0;
                model_reset();
            end else begin
                rstn = 1'b1;
            end
            for (int s = 0; s < NS; s++) begin
                if ($urandom % 12 == 0) t = NM'($urandom % 4);
                else t = NM'(1 << ($urandom % 2));
                set_s(s, ($urandom % 4) != 0, t, ID_W'($urandom), DATA_W'($urandom),
                      ($urandom % 3) == 0, 2'($urandom));
            end
            m_rready = NM'($urandom);
            sample();
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL rand_cyc%0d got=%h want=%h", c, obs(), expv());
            end
            tick();
        end
        rstn = 1'b1;
        clear_all();
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_burst_lock();
        test_parallel();
        test_arbitration();
        test_bad_tag();
        test_stall_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
